// File: rtl/offnariscv_pkg.sv
// Shared types for the writeback stage: result beats from the ALU and LSU
// streams, datapath width and the arbiter's streak-counter width.
package offnariscv_pkg;

  localparam int XLEN     = 32;
  localparam int STREAK_W = 4;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
  } aluwb_tdata_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
  } lsuwb_tdata_t;

  // x0 is hardwired to zero, so a result aimed at it must never reach the RF.
  function automatic logic writes_rf(input logic [4:0] rd);
    return rd != 5'd0;
  endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream style handshake (tvalid/tready/tdata) with master and
// slave modports.
interface axis_if #(
  parameter int unsigned DW = 32
);
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/wb_prio_arb.sv
// Writeback arbiter: LSU has fixed priority over ALU, but after STARVE_MAX
// consecutive LSU grants with ALU waiting, ALU is granted once.
module wb_prio_arb
  import offnariscv_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic invalidate,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic alu_ready,
  output logic lsu_ready
);

  logic [STREAK_W-1:0] streak_d, streak_q;
  logic                lsu_wins;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    lsu_wins  = lsu_valid && !(alu_valid && streak_q == STREAK_W'(STARVE_MAX));
    alu_ready = !rst && !invalidate && alu_valid && !lsu_wins;
    lsu_ready = !rst && !invalidate && lsu_wins;

    streak_d = streak_q;
    if (!alu_valid || alu_ready) begin
      streak_d = '0;
    end else if (lsu_ready) begin
      streak_d = streak_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/writeback.sv
// Writeback stage: arbitrates ALU/LSU result streams, registers the accepted
// beat onto the RF write port and the dispatcher bypass. Optional retired-
// instruction counter enabled by defining WB_INSTRET_EN.
module writeback
  import offnariscv_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  axis_if.s               aluwb_axis_if,
  axis_if.s               lsuwb_axis_if,
  input  logic            invalidate,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data,
  output logic            retire
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  aluwb_tdata_t    alu_beat;
  lsuwb_tdata_t    lsu_beat;
  logic            alu_ready, lsu_ready;
  logic            alu_fire, lsu_fire;
  logic            rf_we_d, rf_we_q;
  logic [4:0]      rf_waddr_d, rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_d, rf_wdata_q;
  logic            retire_d, retire_q;

  assign alu_beat = aluwb_axis_if.tdata;
  assign lsu_beat = lsuwb_axis_if.tdata;

  wb_prio_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .invalidate (invalidate),
    .alu_valid  (aluwb_axis_if.tvalid),
    .lsu_valid  (lsuwb_axis_if.tvalid),
    .alu_ready  (alu_ready),
    .lsu_ready  (lsu_ready)
  );

  assign aluwb_axis_if.tready = alu_ready;
  assign lsuwb_axis_if.tready = lsu_ready;
  assign alu_fire = aluwb_axis_if.tvalid && alu_ready;
  assign lsu_fire = lsuwb_axis_if.tvalid && lsu_ready;

  // Address/data hold when idle; only the strobes drop.
  always_comb begin
    rf_we_d    = 1'b0;
    retire_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (lsu_fire) begin
      retire_d   = 1'b1;
      rf_we_d    = writes_rf(lsu_beat.rd);
      rf_waddr_d = lsu_beat.rd;
      rf_wdata_d = lsu_beat.result;
    end else if (alu_fire) begin
      retire_d   = 1'b1;
      rf_we_d    = writes_rf(alu_beat.rd);
      rf_waddr_d = alu_beat.rd;
      rf_wdata_d = alu_beat.result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      retire_q   <= 1'b0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      retire_q   <= retire_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign retire    = retire_q;
  assign fwd_valid = rf_we_q;
  assign fwd_rd    = rf_waddr_q;
  assign fwd_data  = rf_wdata_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_d, instret_q;

  // Counts one cycle behind the retire pulse; wraps naturally at 2^64.
  always_comb begin
    instret_d = instret_q + 64'(retire_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for writeback (STARVE_MAX=4); instret checks
// are compiled in when WB_INSTRET_EN is defined.
module tb_writeback;
  import offnariscv_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            invalidate;
  logic            rf_we, fwd_valid, retire;
  logic [4:0]      rf_waddr, fwd_rd;
  logic [XLEN-1:0] rf_wdata, fwd_data;
`ifdef WB_INSTRET_EN
  logic [63:0]     instret;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  axis_if #(.DW($bits(aluwb_tdata_t))) alu_if ();
  axis_if #(.DW($bits(lsuwb_tdata_t))) lsu_if ();

  writeback #(.STARVE_MAX(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .aluwb_axis_if (alu_if),
    .lsuwb_axis_if (lsu_if),
    .invalidate    (invalidate),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .retire        (retire)
`ifdef WB_INSTRET_EN
    ,
    .instret       (instret)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] res);
    aluwb_tdata_t b;
    b.rd = rd;
    b.result = res;
    alu_if.tvalid = v;
    alu_if.tdata  = b;
  endtask

  task automatic drive_lsu(input logic v, input logic [4:0] rd, input logic [XLEN-1:0] res);
    lsuwb_tdata_t b;
    b.rd = rd;
    b.result = res;
    lsu_if.tvalid = v;
    lsu_if.tdata  = b;
  endtask

  task automatic check_write(input string tag, input logic we, input logic [4:0] rd,
                             input logic [XLEN-1:0] data, input logic ret);
    check({tag, ".rf_we"},     rf_we, we);
    check({tag, ".rf_waddr"},  rf_waddr, rd);
    check({tag, ".rf_wdata"},  rf_wdata, data);
    check({tag, ".retire"},    retire, ret);
    check({tag, ".fwd_valid"}, fwd_valid, we);
    check({tag, ".fwd_rd"},    fwd_rd, rd);
    check({tag, ".fwd_data"},  fwd_data, data);
  endtask

  initial begin
    logic exp_lsu;
    rst = 1'b1;
    invalidate = 1'b0;
    drive_alu(1'b0, 5'd0, '0);
    drive_lsu(1'b0, 5'd0, '0);

    // Beat presented during reset must be discarded.
    tick();
    drive_alu(1'b1, 5'd3, 32'hDEAD);
    #1;
    check("rst.alu_tready", alu_if.tready, 1'b0);
    tick();
    check_write("rst", 1'b0, 5'd0, 32'h0, 1'b0);
    rst = 1'b0;
    drive_alu(1'b0, 5'd0, '0);
    tick();
    check_write("rst_leak", 1'b0, 5'd0, 32'h0, 1'b0);

    // Single ALU result, latency 1, then address/data hold while idle.
    drive_alu(1'b1, 5'd5, 32'h1234);
    #1;
    check("alu1.tready", alu_if.tready, 1'b1);
    tick();
    drive_alu(1'b0, 5'd0, '0);
    check_write("alu1", 1'b1, 5'd5, 32'h1234, 1'b1);
    tick();
    check_write("idle", 1'b0, 5'd5, 32'h1234, 1'b0);

    // rd=0: no RF write, retire still pulses.
    drive_lsu(1'b1, 5'd0, 32'hFFFF_FFFF);
    tick();
    drive_lsu(1'b0, 5'd0, '0);
    check_write("x0", 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1);

    // Both valid every cycle: LSU x4 then ALU, repeating.
    for (int i = 0; i < 10; i++) begin
      drive_alu(1'b1, 5'd1, 32'hA000 + i);
      drive_lsu(1'b1, 5'd2, 32'hB000 + i);
      exp_lsu = (i % 5) != 4;
      #1;
      check($sformatf("starve%0d.lsu_tready", i), lsu_if.tready, exp_lsu);
      check($sformatf("starve%0d.alu_tready", i), alu_if.tready, !exp_lsu);
      tick();
      check($sformatf("starve%0d.rf_waddr", i), rf_waddr, exp_lsu ? 5'd2 : 5'd1);
      check($sformatf("starve%0d.rf_wdata", i), rf_wdata,
            exp_lsu ? 32'hB000 + i : 32'hA000 + i);
    end

    // Flush for 2 cycles; the write registered at the last edge still lands.
    invalidate = 1'b1;
    #1;
    check("flush0.alu_tready", alu_if.tready, 1'b0);
    check("flush0.lsu_tready", lsu_if.tready, 1'b0);
    check_write("flush0", 1'b1, 5'd1, 32'hA009, 1'b1);
    tick();
    check("flush1.lsu_tready", lsu_if.tready, 1'b0);
    check("flush1.alu_tready", alu_if.tready, 1'b0);
    check_write("flush1", 1'b0, 5'd1, 32'hA009, 1'b0);
    tick();
    check_write("flush2", 1'b0, 5'd1, 32'hA009, 1'b0);
    invalidate = 1'b0;
    #1;
    check("post_flush.lsu_tready", lsu_if.tready, 1'b1);

    // Reset in the middle of back-to-back traffic.
    tick();
    check_write("b2b", 1'b1, 5'd2, 32'hB009, 1'b1);
    rst = 1'b1;
    #1;
    check("rst2.lsu_tready", lsu_if.tready, 1'b0);
    tick();
    check_write("rst2", 1'b0, 5'd0, 32'h0, 1'b0);
    rst = 1'b0;
    drive_alu(1'b0, 5'd0, '0);
    drive_lsu(1'b0, 5'd0, '0);
    tick();
    check_write("rst2_leak", 1'b0, 5'd0, 32'h0, 1'b0);
`ifdef WB_INSTRET_EN
    check("instret.reset", instret, 64'd0);
`endif

    // 3 ALU + 2 LSU results, one per cycle.
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive_alu(1'b1, 5'(10 + i), 32'(i));
      else       drive_lsu(1'b1, 5'(10 + i), 32'(i));
      tick();
      drive_alu(1'b0, 5'd0, '0);
      drive_lsu(1'b0, 5'd0, '0);
      check_write($sformatf("seq%0d", i), 1'b1, 5'(10 + i), 32'(i), 1'b1);
    end
    tick();
    tick();
`ifdef WB_INSTRET_EN
    check("instret.five", instret, 64'd5);
`endif
    check("seq.idle_retire", retire, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
